// File: rtl/srt4_pkg.sv
// Shared definitions for the SRT4 quotient path: digit magnitude codes,
// converter state encoding and default sizing.
package srt4_pkg;

    localparam int DIG_NUM_DEF = 16;
    localparam int QW_DEF      = 2 * DIG_NUM_DEF;

    localparam logic [1:0] SRT4_Q0 = 2'b00;
    localparam logic [1:0] SRT4_Q1 = 2'b01;
    localparam logic [1:0] SRT4_Q2 = 2'b10;
    localparam logic [1:0] SRT4_QX = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_REM  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/srt4_otf_convert_if.sv
// Digit, remainder and quotient handshake bundle between the SRT4 iteration
// datapath (master) and the on-the-fly converter (slave).
interface srt4_otf_convert_if #(
    parameter int QW = 32
);
    logic          flush_i;
    logic          start_i;
    logic          digit_vld_i;
    logic          digit_rdy_o;
    logic [1:0]    digit_mag_i;
    logic          digit_neg_i;
    logic          rem_vld_i;
    logic          rem_neg_i;
    logic [QW-1:0] quo_o;
    logic          quo_vld_o;
    logic          quo_rdy_i;
    logic          busy_o;
    logic          err_o;

    modport master (
        output flush_i, start_i, digit_vld_i, digit_mag_i, digit_neg_i,
               rem_vld_i, rem_neg_i, quo_rdy_i,
        input  digit_rdy_o, quo_o, quo_vld_o, busy_o, err_o
    );

    modport slave (
        input  flush_i, start_i, digit_vld_i, digit_mag_i, digit_neg_i,
               rem_vld_i, rem_neg_i, quo_rdy_i,
        output digit_rdy_o, quo_o, quo_vld_o, busy_o, err_o
    );

endinterface

// File: rtl/srt4_otf_step.sv
// Single-digit on-the-fly update of the Q / QM pair (QM = Q - 1 ulp).
// Purely combinational; an illegal magnitude is folded to a zero digit.
module srt4_otf_step
    import srt4_pkg::*;
#(
    parameter int QW = QW_DEF
) (
    input  logic [QW-1:0] q,
    input  logic [QW-1:0] qm,
    input  logic [1:0]    mag,
    input  logic          neg,
    output logic [QW-1:0] q_nxt,
    output logic [QW-1:0] qm_nxt,
    output logic          illegal
);

    logic [1:0] eff_mag;
    logic [1:0] dig;
    logic [1:0] dig_m1;
    logic       dig_lt0;
    logic       dig_gt0;

    // The appended digit is q mod 4 for Q and (q-1) mod 4 for QM; only the
    // source register depends on the sign of q.
    always_comb begin
        illegal = (mag == SRT4_QX);
        eff_mag = illegal ? SRT4_Q0 : mag;
        dig_lt0 = neg && (eff_mag != SRT4_Q0);
        dig_gt0 = !neg && (eff_mag != SRT4_Q0);
        dig     = dig_lt0 ? (~eff_mag + 2'd1) : eff_mag;
        dig_m1  = dig - 2'd1;
        q_nxt   = dig_lt0 ? {qm[QW-3:0], dig} : {q[QW-3:0], dig};
        qm_nxt  = dig_gt0 ? {q[QW-3:0], dig_m1} : {qm[QW-3:0], dig_m1};
    end

endmodule

// File: rtl/srt4_otf_convert.sv
// On-the-fly conversion of signed radix-4 SRT quotient digits into a
// two's-complement quotient, with final negative-remainder correction.
module srt4_otf_convert
    import srt4_pkg::*;
#(
    parameter int DIG_NUM = DIG_NUM_DEF,
    parameter int QW      = QW_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    srt4_otf_convert_if.slave     bus
);

    localparam int                CNT_W    = $clog2(DIG_NUM);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIG_NUM - 1);

    state_t         state;
    logic [CNT_W-1:0] cnt;
    logic [QW-1:0]  q_reg;
    logic [QW-1:0]  qm_reg;
    logic [QW-1:0]  quo_reg;
    logic [QW-1:0]  q_nxt;
    logic [QW-1:0]  qm_nxt;
    logic           illegal;
    logic           err_reg;
    logic           rdy_reg;
    logic           vld_reg;
    logic           busy_reg;

    srt4_otf_step #(.QW(QW)) u_step (
        .q       (q_reg),
        .qm      (qm_reg),
        .mag     (bus.digit_mag_i),
        .neg     (bus.digit_neg_i),
        .q_nxt   (q_nxt),
        .qm_nxt  (qm_nxt),
        .illegal (illegal)
    );

    // Flush overrides every state and leaves quo_reg untouched so the last
    // result stays visible on quo_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            q_reg    <= '0;
            qm_reg   <= '1;
            quo_reg  <= '0;
            err_reg  <= 1'b0;
            rdy_reg  <= 1'b0;
            vld_reg  <= 1'b0;
            busy_reg <= 1'b0;
        end else if (bus.flush_i) begin
            state    <= ST_IDLE;
            rdy_reg  <= 1'b0;
            vld_reg  <= 1'b0;
            busy_reg <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        state    <= ST_CONV;
                        cnt      <= '0;
                        q_reg    <= '0;
                        qm_reg   <= '1;
                        err_reg  <= 1'b0;
                        rdy_reg  <= 1'b1;
                        busy_reg <= 1'b1;
                    end
                end
                ST_CONV: begin
                    if (bus.digit_vld_i) begin
                        q_reg   <= q_nxt;
                        qm_reg  <= qm_nxt;
                        cnt     <= cnt + CNT_W'(1);
                        err_reg <= err_reg | illegal;
                        if (cnt == CNT_LAST) begin
                            state   <= ST_REM;
                            rdy_reg <= 1'b0;
                        end
                    end
                end
                ST_REM: begin
                    if (bus.rem_vld_i) begin
                        state   <= ST_DONE;
                        quo_reg <= bus.rem_neg_i ? qm_reg : q_reg;
                        vld_reg <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.quo_rdy_i) begin
                        state    <= ST_IDLE;
                        vld_reg  <= 1'b0;
                        busy_reg <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    rdy_reg  <= 1'b0;
                    vld_reg  <= 1'b0;
                    busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.digit_rdy_o = rdy_reg;
    assign bus.quo_o       = quo_reg;
    assign bus.quo_vld_o   = vld_reg;
    assign bus.busy_o      = busy_reg;
    assign bus.err_o       = err_reg;

endmodule
